// File: rtl/phy_pkg.sv
// Shared PHY definitions: symbol width, the COM training/idle-fill symbol and TX serializer states.
package phy_pkg;

  localparam int unsigned SYM_WIDTH      = 8;
  localparam logic [7:0]  COM_SYM        = 8'hBC;
  localparam int unsigned TRAIN_SYMS_DEF = 4;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/phy_tx_par_to_serial.sv
// PHY-TX serializer: one symbol per WIDTH clk_8f cycles, MSB first, with COM training after
// power-up or tx_en loss and COM idle fill for empty byte slots.
module phy_tx_par_to_serial
  import phy_pkg::*;
#(
  parameter int unsigned      WIDTH      = SYM_WIDTH,
  parameter logic [WIDTH-1:0] COM        = COM_SYM,
  parameter int unsigned      TRAIN_SYMS = TRAIN_SYMS_DEF
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic             tx_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             data_ready,
  output logic             data_out,
  output logic             symbol_start,
  output logic             tx_active
);

  localparam int unsigned     CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned     TW         = $clog2(TRAIN_SYMS + 1);
  localparam logic [CW-1:0]   LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [TW-1:0]   LAST_TRAIN = TW'(TRAIN_SYMS - 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] next_sym;
  logic [CW-1:0]    bit_cnt;
  logic [TW-1:0]    train_cnt;
  logic [TW-1:0]    train_cnt_next;
  tx_state_e        state;
  tx_state_e        state_next;
  logic             boundary;
  logic             last_train;

  always_comb begin
    boundary       = (bit_cnt == LAST_BIT);
    last_train     = (state == TRAIN) && tx_en && (train_cnt == LAST_TRAIN);
    data_ready     = boundary && tx_en && ((state == ACTIVE) || last_train);
    next_sym       = (data_ready && valid_in) ? data_in : COM;
    state_next     = state;
    train_cnt_next = train_cnt;
    // FSM only moves on symbol boundaries so a symbol is never cut short
    if (boundary) begin
      if (state == TRAIN) begin
        if (!tx_en) begin
          train_cnt_next = '0;
        end else if (last_train) begin
          state_next = ACTIVE;
        end else begin
          train_cnt_next = train_cnt + 1'b1;
        end
      end else if (!tx_en) begin
        state_next     = TRAIN;
        train_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      sh           <= COM;
      bit_cnt      <= '0;
      state        <= TRAIN;
      train_cnt    <= '0;
      data_out     <= 1'b0;
      symbol_start <= 1'b0;
      tx_active    <= 1'b0;
    end else begin
      data_out     <= sh[WIDTH-1];
      symbol_start <= (bit_cnt == '0);
      // Registered from the state register so it lines up with the serial bit it describes
      tx_active    <= (state == ACTIVE);
      state        <= state_next;
      train_cnt    <= train_cnt_next;
      if (boundary) begin
        bit_cnt <= '0;
        sh      <= next_sym;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        sh      <= sh << 1;
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_par_to_serial.sv
// Self-checking bench for phy_tx_par_to_serial: symbol-level queue model, vector table and corner sequences.
module tb_phy_tx_par_to_serial;

  localparam int unsigned TS  = 4;
  localparam logic [7:0]  COM = 8'hBC;

  logic       clk_8f = 1'b0;
  logic       reset_L = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       data_ready;
  logic       data_out;
  logic       symbol_start;
  logic       tx_active;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queue of serial bits still to be sent for the current slot
  bit         m_q[$];
  bit         m_act;
  int         m_trains;
  bit         m_slot_act;
  bit         exp_do, exp_ss, exp_ta;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [7:0] exp_sym;
  } vec_t;
  vec_t vecs[6];

  phy_tx_par_to_serial #(.TRAIN_SYMS(TS)) dut (
    .clk_8f      (clk_8f),
    .reset_L     (reset_L),
    .tx_en       (tx_en),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .symbol_start(symbol_start),
    .tx_active   (tx_active)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_sym(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) m_q.push_back(s[i]);
  endtask

  task automatic model_reset();
    m_q.delete();
    push_sym(COM);
    m_act      = 1'b0;
    m_trains   = 0;
    m_slot_act = 1'b0;
  endtask

  function automatic bit model_ready();
    return (m_q.size() == 1) && tx_en && (m_act || (m_trains == TS - 1));
  endfunction

  task automatic model_step();
    logic [7:0] sym;
    exp_ss = (m_q.size() == 8);
    exp_do = m_q.pop_front();
    exp_ta = m_slot_act;
    if (m_q.size() == 0) begin
      sym = COM;
      if (m_act) begin
        if (tx_en) sym = valid_in ? data_in : COM;
        else begin
          m_act    = 1'b0;
          m_trains = 0;
        end
      end else if (!tx_en) begin
        m_trains = 0;
      end else if (m_trains == TS - 1) begin
        m_act = 1'b1;
        sym   = valid_in ? data_in : COM;
      end else begin
        m_trains++;
      end
      push_sym(sym);
      m_slot_act = m_act;
    end
  endtask

  task automatic tick(output logic rdy);
    #1;
    rdy = data_ready;
    chk("data_ready", {31'd0, data_ready}, {31'd0, model_ready()});
    @(posedge clk_8f);
    model_step();
    #1;
    chk("data_out", {31'd0, data_out}, {31'd0, exp_do});
    chk("symbol_start", {31'd0, symbol_start}, {31'd0, exp_ss});
    chk("tx_active", {31'd0, tx_active}, {31'd0, exp_ta});
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    chk("rst_data_out", {31'd0, data_out}, 32'd0);
    chk("rst_symbol_start", {31'd0, symbol_start}, 32'd0);
    chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk_8f);
    #3;
    reset_L = 1'b1;
  endtask

  task automatic wait_ready(input int maxc, output int n);
    logic r;
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      tick(r);
      if (r) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture(output logic [7:0] b, output logic ss0, output logic ta0, output logic rdy_last);
    logic r;
    b = '0;
    ss0 = 1'b0;
    ta0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(r);
      b = {b[6:0], data_out};
      if (i == 0) begin
        ss0 = symbol_start;
        ta0 = tx_active;
      end
    end
    rdy_last = r;
  endtask

  task automatic train_check();
    logic [31:0] bits = '0;
    logic        r;
    logic [7:0]  b;
    logic        ss0, ta0, rl;
    int          first = 0;
    tx_en = 1'b1;
    valid_in = 1'b1;
    data_in = 8'hA5;
    for (int t = 1; t <= 40; t++) begin
      tick(r);
      if (t <= 32) bits = {bits[30:0], data_out};
      if (r) begin
        first = t;
        break;
      end
    end
    chk("train_ready_cycle", first, 32'd32);
    chk("train_bits", bits, 32'hBCBCBCBC);
    capture(b, ss0, ta0, rl);
    chk("first_data_sym", {24'd0, b}, 32'hA5);
    chk("first_data_ss", {31'd0, ss0}, 32'd1);
    chk("first_data_ta", {31'd0, ta0}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    logic       ss0, ta0, rl, r;
    int         n;

    vecs[0] = '{valid: 1'b0, data: 8'h00, exp_sym: 8'hBC};
    vecs[1] = '{valid: 1'b1, data: 8'h3C, exp_sym: 8'h3C};
    vecs[2] = '{valid: 1'b1, data: 8'h00, exp_sym: 8'h00};
    vecs[3] = '{valid: 1'b1, data: 8'hFF, exp_sym: 8'hFF};
    vecs[4] = '{valid: 1'b0, data: 8'h5A, exp_sym: 8'hBC};
    vecs[5] = '{valid: 1'b1, data: 8'h81, exp_sym: 8'h81};

    #2;
    do_reset();
    train_check();

    foreach (vecs[i]) begin
      valid_in = vecs[i].valid;
      data_in  = vecs[i].data;
      wait_ready(16, n);
      capture(b, ss0, ta0, rl);
      chk($sformatf("vec%0d_sym", i), {24'd0, b}, {24'd0, vecs[i].exp_sym});
      chk($sformatf("vec%0d_active", i), {31'd0, ta0}, 32'd1);
    end

    // tx_en drops mid-symbol: symbol completes, then COM with tx_active low, then full retraining
    valid_in = 1'b1;
    data_in  = 8'h96;
    wait_ready(16, n);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) tx_en = 1'b0;
      tick(r);
      b = {b[6:0], data_out};
    end
    chk("drop_sym_intact", {24'd0, b}, 32'h96);
    tx_en = 1'b1;
    capture(b, ss0, ta0, rl);
    chk("drop_com", {24'd0, b}, {24'd0, COM});
    chk("drop_tx_active", {31'd0, ta0}, 32'd0);
    wait_ready(40, n);
    chk("retrain_len", n, 32'd24);

    // async reset in the middle of a data symbol
    data_in = 8'hFC;
    wait_ready(16, n);
    for (int i = 0; i < 5; i++) tick(r);
    #2;
    do_reset();
    train_check();

    // 256-byte back-to-back stream
    data_in  = 8'h00;
    valid_in = 1'b1;
    wait_ready(16, n);
    for (int k = 1; k <= 256; k++) begin
      data_in = 8'(k);
      capture(b, ss0, ta0, rl);
      chk("stream_byte", {24'd0, b}, k - 1);
      chk("stream_ready_period", {31'd0, rl}, 32'd1);
    end

    // randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      valid_in = ($urandom_range(3) != 0);
      data_in  = 8'($urandom);
      if ($urandom_range(39) == 0) tx_en = ~tx_en;
      tick(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
